// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Iteration counter width for a given operand width.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int DEF_WIDTH = 16;
    localparam int CNT_W     = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/div_seq_sub_rca.sv
// Ripple-borrow subtractor: d = a + ~b + 1, built as 4-bit ripple stages
// followed by a single top bit. bout=1 means a < b (unsigned).
module sub_rca #(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] d_o,
    output logic             bout_o
);
    localparam int NSTG = (WIDTH - 1) / 4;

    // c[g] is the carry into 4-bit stage g; c[NSTG] feeds the top bit.
    logic [NSTG:0] c;
    assign c[0] = 1'b1;

    for (genvar g = 0; g < NSTG; g++) begin : g_stage
        logic [4:0] cc;
        logic [3:0] nb;
        assign cc[0] = c[g];
        for (genvar b = 0; b < 4; b++) begin : g_bit
            assign nb[b]         = ~b_i[4*g+b];
            assign d_o[4*g+b]    = a_i[4*g+b] ^ nb[b] ^ cc[b];
            assign cc[b+1]       = (a_i[4*g+b] & nb[b]) | (a_i[4*g+b] & cc[b]) | (nb[b] & cc[b]);
        end
        assign c[g+1] = cc[4];
    end

    logic nb_top;
    logic cout;
    assign nb_top         = ~b_i[WIDTH-1];
    assign d_o[WIDTH-1]   = a_i[WIDTH-1] ^ nb_top ^ c[NSTG];
    assign cout           = (a_i[WIDTH-1] & nb_top) | (a_i[WIDTH-1] & c[NSTG]) | (nb_top & c[NSTG]);
    // No carry out of a + ~b + 1 means the subtraction borrowed.
    assign bout_o         = ~cout;

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] q_q, divisor_q, quotient_q, remainder_q;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, dbz_q;

    logic [WIDTH:0]   t, diff;
    logic             bout_w, borrow;
    logic [WIDTH-1:0] q_d, r_d;
    logic             accept;

    // Partial remainder shifted left with the next dividend bit; R's guard
    // bit is always zero after an iteration, so only WIDTH bits are kept.
    assign t = {r_q, q_q[WIDTH-1]};

    sub_rca #(.WIDTH(WIDTH + 1)) u_sub (
        .a_i    (t),
        .b_i    ({1'b0, divisor_q}),
        .d_o    (diff),
        .bout_o (bout_w)
    );

    // The top difference bit and the chain's borrow agree; either marks T < divisor.
    assign borrow = bout_w | diff[WIDTH];
    assign r_d    = borrow ? t[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_d    = {q_q[WIDTH-2:0], ~borrow};

    // Start is honoured in IDLE and in a settled DONE cycle (busy low).
    assign accept = start_i && !busy_q && (state_q == IDLE || state_q == DONE);

    // Control FSM, counter and Q/R datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            q_q         <= '0;
            r_q         <= '0;
            divisor_q   <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else if (accept) begin
            divisor_q <= divisor_i;
            q_q       <= dividend_i;
            r_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            if (divisor_i == '0) begin
                // Result is known now; DONE holds busy for one cycle before strobing.
                dbz_q       <= 1'b1;
                quotient_q  <= '1;
                remainder_q <= dividend_i;
                state_q     <= DONE;
            end else begin
                dbz_q   <= 1'b0;
                state_q <= RUN;
            end
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    q_q   <= q_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= q_d;
                        remainder_q <= r_d;
                    end
                end
                DONE: begin
                    if (busy_q) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus queues expected results, a monitor
// checks them (and accept-to-done latency) whenever done is presented.
module tb_div_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend, divisor;
    logic        busy, done, dbz;
    logic [15:0] quotient, remainder;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(16)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .busy_o        (busy),
        .done_o        (done),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (dbz)
    );

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Edge counter and log of accepted starts (reset discards pending ones).
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) acc_q.delete();
        else if (start && !busy) acc_q.push_back(cyc);
    end

    // Monitor: every done must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", {31'd0, done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                chk("quotient", {16'd0, quotient}, {16'd0, e.q});
                chk("remainder", {16'd0, remainder}, {16'd0, e.r});
                chk("div_by_zero", {31'd0, dbz}, {31'd0, e.dbz});
                chk("latency", cyc - a, e.lat);
            end
        end
    end

    task automatic push(input logic [15:0] q, input logic [15:0] r, input logic z, input int lat);
        exp_t e;
        e.q = q; e.r = r; e.dbz = z; e.lat = lat;
        exp_q.push_back(e);
    endtask

    // One-cycle start pulse; returns at the falling edge after the accept edge.
    task automatic go(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, {31'd0, busy}, 0);
        chk({nm, "_done"}, {31'd0, done}, 0);
        chk({nm, "_q"}, {16'd0, quotient}, 0);
        chk({nm, "_r"}, {16'd0, remainder}, 0);
        chk({nm, "_dbz"}, {31'd0, dbz}, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Basic divide with latency and busy/done handshake.
        push(16'd14, 16'd2, 1'b0, 16);
        go(16'd100, 16'd7);
        chk("busy_after_accept", {31'd0, busy}, 1);
        chk("done_low_in_run", {31'd0, done}, 0);
        drain();
        chk("done_dropped", {31'd0, done}, 0);
        chk("idle_not_busy", {31'd0, busy}, 0);

        // Operand corners.
        push(16'hFFFF, 16'd0, 1'b0, 16); go(16'hFFFF, 16'd1);     drain();
        push(16'd0,    16'd3, 1'b0, 16); go(16'd3, 16'd10);       drain();
        push(16'd1,    16'd0, 1'b0, 16); go(16'hFFFF, 16'hFFFF);  drain();

        // Divide by zero, then a normal divide clears the flag.
        push(16'hFFFF, 16'd5, 1'b1, 1);
        go(16'd5, 16'd0);
        chk("dbz_busy_one_cycle", {31'd0, busy}, 1);
        drain();
        push(16'd3, 16'd0, 1'b0, 16); go(16'd9, 16'd3); drain();

        // Start while running is ignored.
        push(16'd14, 16'd2, 1'b0, 16);
        go(16'd100, 16'd7);
        repeat (3) @(negedge clk);
        dividend = 16'd50; divisor = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (20) @(negedge clk);
        chk("no_second_accept", acc_q.size(), 0);

        // Reset mid-run discards the operation.
        go(16'd100, 16'd7);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("midrun_reset");
        rst_n = 1'b1;
        push(16'd30, 16'd10, 1'b0, 16); go(16'd1000, 16'd33); drain();

        // Start held high: three back-to-back results, 17 cycles apart.
        repeat (3) push(16'd22, 16'd2, 1'b0, 16);
        @(negedge clk);
        dividend = 16'd200; divisor = 16'd9; start = 1'b1;
        repeat (35) @(negedge clk);
        start = 1'b0;
        drain();
        repeat (20) @(negedge clk);
        chk("b2b_accepts_consumed", acc_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
